// File: rtl/reg_file_2r1w_if.sv
// Decode/writeback side bundle for the 2-read/1-write integer register file.
interface reg_file_2r1w_if #(
  parameter int unsigned n      = 32,
  parameter int unsigned ADDR_W = 5
);

  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [n-1:0]      rd_data;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [n-1:0]      rs1_data;
  logic [n-1:0]      rs2_data;

  // Pipeline side: issues the write and both read addresses, consumes read data.
  modport master (
    output wr_en, rd_addr, rd_data, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data
  );

  // Register file side.
  modport slave (
    input  wr_en, rd_addr, rd_data, rs1_addr, rs2_addr,
    output rs1_data, rs2_data
  );

endinterface

// File: rtl/reg_file_2r1w.sv
// RISC-V integer register file: 2 combinational read ports, 1 synchronous
// write port, x0 hardwired to zero, optional same-cycle write-to-read bypass.
module reg_file_2r1w #(
  parameter int unsigned n      = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  reg_file_2r1w_if.slave   bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam bit          BYP_EN = (BYPASS != 0);

  logic [n-1:0] mem [DEPTH];

  logic         wr_live;
  logic [n-1:0] rs1_val;
  logic [n-1:0] rs2_val;

  // A write that will actually commit on the coming edge (reset kills it, x0 ignores it).
  assign wr_live = bus.wr_en && !rst && (bus.rd_addr != '0);

  // Storage array: synchronous clear, then gated write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_live) begin
      mem[bus.rd_addr] <= bus.rd_data;
    end
  end

  // Read port 1: x0 forces zero, then bypass of the in-flight write, then array.
  always_comb begin
    rs1_val = '0;
    if (bus.rs1_addr != '0) begin
      if (BYP_EN && wr_live && (bus.rd_addr == bus.rs1_addr)) begin
        rs1_val = bus.rd_data;
      end else begin
        rs1_val = mem[bus.rs1_addr];
      end
    end
  end

  // Read port 2: same rules as port 1, resolved independently.
  always_comb begin
    rs2_val = '0;
    if (bus.rs2_addr != '0) begin
      if (BYP_EN && wr_live && (bus.rd_addr == bus.rs2_addr)) begin
        rs2_val = bus.rd_data;
      end else begin
        rs2_val = mem[bus.rs2_addr];
      end
    end
  end

  assign bus.rs1_data = rs1_val;
  assign bus.rs2_data = rs2_val;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: one bypassing and one non-bypassing
// instance driven with identical stimulus, checked against an array model.
module tb_reg_file_2r1w;

  logic clk;
  logic rst;

  reg_file_2r1w_if #(.n(32), .ADDR_W(5)) bus_b ();
  reg_file_2r1w_if #(.n(32), .ADDR_W(5)) bus_n ();

  reg_file_2r1w #(.n(32), .ADDR_W(5), .BYPASS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  reg_file_2r1w #(.n(32), .ADDR_W(5), .BYPASS(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  typedef struct {
    logic [31:0] e1b;
    logic [31:0] e2b;
    logic [31:0] e1n;
    logic [31:0] e2n;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model[32];
  int          vectors    = 0;
  int          miscompares = 0;
  bit          done       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural read as seen before the coming edge.
  function automatic logic [31:0] exp_read(input bit byp, input int addr,
                                           input bit r, input bit we,
                                           input int waddr, input logic [31:0] wdata);
    if (addr == 0) return 32'h0;
    if (byp && !r && we && waddr != 0 && waddr == addr) return wdata;
    return model[addr];
  endfunction

  // One clock of stimulus; pushes expectations when chk is set, then advances the model.
  task automatic cycle(input bit r, input bit we, input int waddr,
                       input logic [31:0] wdata, input int a1, input int a2,
                       input bit chk);
    exp_t e;
    rst = r;
    bus_b.wr_en = we;     bus_n.wr_en = we;
    bus_b.rd_addr = 5'(waddr); bus_n.rd_addr = 5'(waddr);
    bus_b.rd_data = wdata; bus_n.rd_data = wdata;
    bus_b.rs1_addr = 5'(a1); bus_n.rs1_addr = 5'(a1);
    bus_b.rs2_addr = 5'(a2); bus_n.rs2_addr = 5'(a2);
    if (chk) begin
      e.e1b = exp_read(1'b1, a1, r, we, waddr, wdata);
      e.e2b = exp_read(1'b1, a2, r, we, waddr, wdata);
      e.e1n = exp_read(1'b0, a1, r, we, waddr, wdata);
      e.e2n = exp_read(1'b0, a2, r, we, waddr, wdata);
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && waddr != 0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic rd(input int a1, input int a2);
    cycle(1'b0, 1'b0, 0, 32'h0, a1, a2, 1'b1);
  endtask

  task automatic wr(input int waddr, input logic [31:0] wdata, input int a1, input int a2);
    cycle(1'b0, 1'b1, waddr, wdata, a1, a2, 1'b1);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: compare the presented read data mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    while (!done || sb_q.size() != 0) begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp("byp_rs1", bus_b.rs1_data, e.e1b);
        cmp("byp_rs2", bus_b.rs2_data, e.e2b);
        cmp("nobyp_rs1", bus_n.rs1_data, e.e1n);
        cmp("nobyp_rs2", bus_n.rs2_data, e.e2n);
      end
    end
  end

  // Stimulus.
  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst = 1'b1;
    bus_b.wr_en = 1'b0; bus_n.wr_en = 1'b0;
    bus_b.rd_addr = '0; bus_n.rd_addr = '0;
    bus_b.rd_data = '0; bus_n.rd_data = '0;
    bus_b.rs1_addr = '0; bus_n.rs1_addr = '0;
    bus_b.rs2_addr = '0; bus_n.rs2_addr = '0;
    @(posedge clk); #1;

    // Initial reset: contents undefined until the first edge, so not checked.
    cycle(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0);
    for (int i = 0; i < 32; i += 4) rd(i, 31 - i);

    // Reset clears a previously written register.
    wr(5, 32'hDEADBEEF, 5, 0);
    rd(5, 5);
    cycle(1'b1, 1'b0, 0, 32'h0, 5, 5, 1'b1);
    rd(5, 5);

    // Basic write then read on both ports.
    wr(7, 32'h12345678, 0, 0);
    rd(7, 7);

    // x0 stays zero even while being written.
    wr(0, 32'hFFFFFFFF, 0, 0);
    rd(0, 0);

    // Bypass vs read-before-write.
    wr(3, 32'h00000011, 0, 0);
    wr(4, 32'h00000044, 0, 0);
    wr(3, 32'h00000022, 3, 4);
    rd(3, 4);
    wr(6, 32'h00000066, 6, 6);

    // Reset and write on the same edge: reset wins, no bypass.
    wr(9, 32'h00000099, 0, 0);
    cycle(1'b1, 1'b1, 9, 32'h000000AA, 9, 9, 1'b1);
    rd(9, 9);

    // Full sweep.
    for (int i = 1; i < 32; i++) wr(i, 32'(i) * 32'h01010101, i, 32 - i);
    for (int i = 0; i < 32; i++) rd(i, (32 - i) & 31);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1) != 0,
            int'($urandom_range(0, 31)), $urandom,
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b1);
    end

    rd(0, 0);
    done = 1'b1;
    repeat (4) @(posedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Integer register file for the RISC-V core: 32 architectural registers, two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- The read side is the consumer of values produced by the load-enabled register bank.
- Sits between decode (read addresses) and writeback (write address/data).
- x0 is hardwired to zero; optional write-to-read bypass lets a value written in the current cycle be read the same cycle.

Parameters:
- n, 32, data width of each register.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = reads return stored contents only.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write enable for the rd port.
- rd_addr  input  ADDR_W  write address.
- rd_data  input  n  write data.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs1_data  output  n  read port 1 data.
- rs2_data  output  n  read port 2 data.

Behaviour:
- Single clock domain clk. rst is synchronous and active-high: it is sampled on the rising edge of clk.
- Reset:
  - On a rising edge of clk with rst=1, every register is set to 0 and any write that cycle is discarded.
  - After reset, rs1_data = rs2_data = 0 for every address.
- Write:
  - On a rising edge with rst=0, wr_en=1 and rd_addr != 0, rd_data is stored at rd_addr.
  - The stored value is visible through the array from the next cycle onward.
  - Writes to address 0 are ignored.
  - wr_en=0 leaves all contents unchanged.
- Read:
  - Combinational, zero latency.
  - rsX_data = 0 when rsX_addr == 0, regardless of wr_en or bypass.
  - Otherwise rsX_data = mem[rsX_addr].
- Bypass (BYPASS=1):
  - When wr_en=1, rd_addr != 0, rd_addr == rsX_addr and rst=0, rsX_data = rd_data in the same cycle.
  - This gives write-before-read semantics.
  - Both read ports are bypassed independently; if both match rd_addr, both return rd_data.
- BYPASS=0: reads return pre-edge contents (read-before-write).
- Simultaneous reset and write: reset wins; the written register is 0 after the edge.
  - During a cycle with rst=1, bypass is suppressed and reads return the current stored contents.
- Both read ports may address the same register; both return identical data.
- No X propagation: all registers have defined values after the first reset edge.
- rs1_data and rs2_data have no internal sequential latency beyond the storage array, so there are no output registers.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, then assert rst for 1 cycle -> rs1_addr=5 reads 0x00000000.
- Basic write/read: write 0x12345678 to x7, next cycle set rs1_addr=7 and rs2_addr=7 -> both ports return 0x12345678.
- x0 protection: wr_en=1, rd_addr=0, rd_data=0xFFFFFFFF -> rs1_addr=0 returns 0 the same cycle and all later cycles.
- Bypass (BYPASS=1): x3 holds 0x11, write 0x22 to x3 with rs1_addr=3, rs2_addr=4 in the same cycle -> rs1_data=0x22 before the edge, rs2_data = old x4 value; with BYPASS=0, rs1_data=0x11 before the edge and 0x22 after.
- Reset vs write: rst=1 and wr_en=1, rd_addr=9, rd_data=0xAA on the same edge -> x9 reads 0 afterwards and no bypass during that cycle.
- Full sweep: write value i*0x01010101 to x1..x31, then read all pairs (i, 32-i) -> each port returns its register's value, and x0 returns 0.
